prio_encoder_rr: RTL



---
 rtl/prio_encoder_rr_pkg.sv | 25 ++
 rtl/prio_encoder_rr_core.sv | 33 +++
 rtl/prio_encoder_rr.sv | 139 +++++++++++++
 3 files changed

// File: rtl/prio_encoder_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_pkg
// Description : Shared constants and helpers for the round-robin priority
//               encoder: mode encodings and a "two or more bits set" test.
// Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

  // Encoding of in_mode.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest request vector at_least_two() can accept. Narrower vectors are
  // zero-extended by the caller, which does not change the result.
  localparam int MAX_REQ = 1024;

  // True when v has two or more bits set: clearing the lowest set bit
  // leaves something behind only if another bit was set.
  function automatic logic at_least_two(input logic [MAX_REQ-1:0] v);
    return |(v & (v - MAX_REQ'(1)));
  endfunction

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/prio_encoder_rr_core.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_core
// Description : Purely combinational fixed-priority encoder. Reports the
//               highest set index of vec and whether any bit was set.
// Ports       : vec   in  N  request vector
//               idx   out W  highest set index (0 when nothing set)
//               found out 1  at least one bit of vec is set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_core #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Ascending scan: the last match, i.e. the highest set bit, wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule : prio_enc_core
`default_nettype wire

// File: rtl/prio_encoder_rr.sv
`default_nettype none
// ============================================================================
// Module      : prio_encoder_rr
// Description : Registered priority encoder with fixed-priority and
//               round-robin modes, valid/ready on both sides, 1-cycle latency.
// Ports       : clk, rst_n            clock, synchronous active-low reset
//               in_valid/in_ready     input handshake
//               in_req   [N]          request vector
//               in_mode               0 = fixed priority, 1 = round-robin
//               out_valid/out_ready   output handshake
//               out_idx  [W]          granted index
//               out_onehot [N]        one-hot grant (zero when none)
//               out_any               any request bit set
//               out_multi             two or more request bits set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_encoder_rr
  import encoder_pkg::*;
#(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_any,
  output logic         out_multi
);

  if (N < 2 || N > MAX_REQ) begin : g_bad_n
    $error("prio_encoder_rr: N must be in 2..%0d", MAX_REQ);
  end

  localparam logic [W:0] N_EXT = (W+1)'(N);

  logic [W-1:0] ptr;
  logic         accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------
  // Fixed-priority search directly on the request vector.
  // ---------------------------------------------------------------------
  logic [W-1:0] fix_idx;
  logic         fix_found;

  prio_enc_core #(.N(N), .W(W)) u_core_fixed (
    .vec   (in_req),
    .idx   (fix_idx),
    .found (fix_found)
  );

  // ---------------------------------------------------------------------
  // Round-robin search: rot_req[j] = in_req[(ptr + j) mod N], so bit ptr-1
  // sits at position N-1 and bit ptr at position 0. The fixed encoder then
  // scans ptr-1, ptr-2, ... wrapping through N-1 and ending at ptr.
  // Rotation uses a doubled vector so no modulo is needed for any N.
  // ---------------------------------------------------------------------
  logic [N-1:0] rot_req;
  logic [W-1:0] rot_idx;
  logic         rot_found;
  logic [W:0]   rr_sum;
  logic [W-1:0] rr_idx;

  assign rot_req = N'({in_req, in_req} >> ptr);

  prio_enc_core #(.N(N), .W(W)) u_core_rr (
    .vec   (rot_req),
    .idx   (rot_idx),
    .found (rot_found)
  );

  // Un-rotate: (ptr + rot_idx) mod N. Both operands are below N, so a single
  // conditional subtract suffices.
  always_comb begin
    rr_sum = {1'b0, ptr} + {1'b0, rot_idx};
    if (rr_sum >= N_EXT) begin
      rr_sum = rr_sum - N_EXT;
    end
    rr_idx = rr_sum[W-1:0];
  end

  // ---------------------------------------------------------------------
  // Result selection.
  // ---------------------------------------------------------------------
  logic [W-1:0] nxt_idx;
  logic         nxt_any;
  logic [N-1:0] nxt_onehot;
  logic         nxt_multi;

  always_comb begin
    nxt_any    = fix_found;
    nxt_idx    = '0;
    nxt_onehot = '0;
    if (nxt_any) begin
      nxt_idx    = (in_mode == MODE_RR && rot_found) ? rr_idx : fix_idx;
      nxt_onehot = N'(1) << nxt_idx;
    end
    nxt_multi = at_least_two(MAX_REQ'(in_req));
  end

  // ---------------------------------------------------------------------
  // Result register, valid flag and shared round-robin pointer.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_any    <= 1'b0;
      out_multi  <= 1'b0;
      ptr        <= '0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_idx    <= nxt_idx;
        out_onehot <= nxt_onehot;
        out_any    <= nxt_any;
        out_multi  <= nxt_multi;
        // An all-zero vector leaves the pointer where it was.
        if (nxt_any) begin
          ptr <= nxt_idx;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : prio_encoder_rr
`default_nettype wire
